// File: rtl/board_judge.sv
// Tic-tac-toe result judge: snapshots both boards on start and scans the 8 lines one per clock.
// Optional draw detection is built when BOARD_JUDGE_DRAW_EN is defined.
module board_judge (
    input  logic       clk,
    input  logic       clr_game,
    input  logic       start,
    input  logic [8:0] b_in,
    input  logic [8:0] r_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic [7:0] win_line,
    output logic       draw,
    output logic       game_over
);

    typedef enum logic [1:0] {StIdle, StScan, StDone, StOver} state_e;

    state_e     state_q, state_d;
    logic [8:0] b_snap_q, r_snap_q;
    logic [2:0] idx_q;
    logic       hit_b_q, hit_r_q;
    logic [7:0] acc_line_q;
    logic [1:0] winner_q;
    logic [7:0] win_line_q;
    logic       draw_q, game_over_q;

    logic [8:0] line_mask;
    logic       blue_full, red_full;
    logic       hit_b_nx, hit_r_nx;
    logic [7:0] acc_line_nx;
    logic       draw_nx;

    always_comb begin
        line_mask = 9'h000;
        unique case (idx_q)
            3'd0: line_mask = 9'h007;
            3'd1: line_mask = 9'h038;
            3'd2: line_mask = 9'h1C0;
            3'd3: line_mask = 9'h049;
            3'd4: line_mask = 9'h092;
            3'd5: line_mask = 9'h124;
            3'd6: line_mask = 9'h111;
            3'd7: line_mask = 9'h054;
            default: line_mask = 9'h000;
        endcase
    end

    always_comb begin
        blue_full   = (b_snap_q & line_mask) == line_mask;
        red_full    = (r_snap_q & line_mask) == line_mask;
        hit_b_nx    = hit_b_q | blue_full;
        hit_r_nx    = hit_r_q | red_full;
        acc_line_nx = acc_line_q;
        if (blue_full || red_full) begin
            acc_line_nx = acc_line_q | (8'd1 << idx_q);
        end
`ifdef BOARD_JUDGE_DRAW_EN
        draw_nx = ((b_snap_q | r_snap_q) == 9'h1FF) && !(hit_b_nx || hit_r_nx);
`else
        draw_nx = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StScan;
            StScan: if (idx_q == 3'd7) state_d = StDone;
            // game_over_q was registered on entry to DONE, so it already reflects this result
            StDone: state_d = game_over_q ? StOver : StIdle;
            StOver: state_d = StOver;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_game) begin
            state_q     <= StIdle;
            b_snap_q    <= 9'h000;
            r_snap_q    <= 9'h000;
            idx_q       <= 3'd0;
            hit_b_q     <= 1'b0;
            hit_r_q     <= 1'b0;
            acc_line_q  <= 8'h00;
            winner_q    <= 2'b00;
            win_line_q  <= 8'h00;
            draw_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                b_snap_q   <= b_in;
                r_snap_q   <= r_in;
                idx_q      <= 3'd0;
                hit_b_q    <= 1'b0;
                hit_r_q    <= 1'b0;
                acc_line_q <= 8'h00;
            end else if (state_q == StScan) begin
                hit_b_q    <= hit_b_nx;
                hit_r_q    <= hit_r_nx;
                acc_line_q <= acc_line_nx;
                if (idx_q != 3'd7) begin
                    idx_q <= idx_q + 3'd1;
                end else begin
                    winner_q    <= {hit_r_nx, hit_b_nx};
                    win_line_q  <= acc_line_nx;
                    draw_q      <= draw_nx;
                    game_over_q <= hit_r_nx | hit_b_nx | draw_nx;
                end
            end
        end
    end

    assign busy      = (state_q == StScan);
    assign done      = (state_q == StDone);
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign draw      = draw_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_board_judge.sv
// Directed self-checking bench for board_judge; honours BOARD_JUDGE_DRAW_EN for the draw case.
module tb_board_judge;

    logic       clk = 1'b0;
    logic       clr_game = 1'b0;
    logic       start = 1'b0;
    logic [8:0] b_in = 9'h000;
    logic [8:0] r_in = 9'h000;
    logic       busy, done, draw, game_over;
    logic [1:0] winner;
    logic [7:0] win_line;

    int checks = 0;
    int passes = 0;

    board_judge dut (
        .clk       (clk),
        .clr_game  (clr_game),
        .start     (start),
        .b_in      (b_in),
        .r_in      (r_in),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_line  (win_line),
        .draw      (draw),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic clear_game();
        @(negedge clk);
        clr_game = 1'b1;
        start    = 1'b0;
        @(negedge clk);
        clr_game = 1'b0;
    endtask

    // Returns at the negedge just after the edge that samples start.
    task automatic pulse_start(input logic [8:0] b, input logic [8:0] r);
        @(negedge clk);
        b_in  = b;
        r_in  = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded watch for done over 12 cycles after the start edge.
    task automatic watch_done(output int cnt, output int at);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                at = k;
            end
        end
    endtask

    task automatic test_reset();
        clear_game();
        checks++;
        if ({busy, done, winner, win_line, draw, game_over} !== 14'h0)
            $display("FAIL reset_outputs: got %b want 0", {busy, done, winner, win_line, draw, game_over});
        else passes++;
    endtask

    task automatic test_blue_row();
        int cnt, at;
        clear_game();
        pulse_start(9'h007, 9'h018);
        checks++;
        if (busy !== 1'b1) $display("FAIL blue_busy: got %b want 1", busy); else passes++;
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || at !== 8) $display("FAIL blue_done_timing: got cnt=%0d at=%0d want 1 at 8", cnt, at);
        else passes++;
        checks++;
        if (winner !== 2'b01) $display("FAIL blue_winner: got %b want 01", winner); else passes++;
        checks++;
        if (win_line !== 8'h01) $display("FAIL blue_line: got %h want 01", win_line); else passes++;
        checks++;
        if (game_over !== 1'b1 || draw !== 1'b0)
            $display("FAIL blue_over: got go=%b draw=%b want 1 0", game_over, draw);
        else passes++;
    endtask

    task automatic test_start_in_over();
        int cnt, at;
        pulse_start(9'h000, 9'h1C0);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 0) $display("FAIL over_start_ignored: got %0d dones want 0", cnt); else passes++;
        checks++;
        if (game_over !== 1'b1 || winner !== 2'b01)
            $display("FAIL over_hold: got go=%b winner=%b want 1 01", game_over, winner);
        else passes++;
    endtask

    task automatic test_red_diag();
        int cnt, at;
        clear_game();
        pulse_start(9'h00B, 9'h054);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || winner !== 2'b10 || win_line !== 8'h80 || draw !== 1'b0)
            $display("FAIL red_diag: got cnt=%0d winner=%b line=%h draw=%b want 1 10 80 0",
                     cnt, winner, win_line, draw);
        else passes++;
    endtask

    task automatic test_double_line();
        int cnt, at;
        clear_game();
        pulse_start(9'h04F, 9'h1B0);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || winner !== 2'b01 || win_line !== 8'h09)
            $display("FAIL double_line: got cnt=%0d winner=%b line=%h want 1 01 09", cnt, winner, win_line);
        else passes++;
    endtask

    task automatic test_draw();
        int cnt, at;
        clear_game();
        pulse_start(9'h18D, 9'h072);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || at !== 8 || winner !== 2'b00)
            $display("FAIL draw_done: got cnt=%0d at=%0d winner=%b want 1 8 00", cnt, at, winner);
        else passes++;
`ifdef BOARD_JUDGE_DRAW_EN
        checks++;
        if (draw !== 1'b1 || game_over !== 1'b1)
            $display("FAIL draw_flags: got draw=%b go=%b want 1 1", draw, game_over);
        else passes++;
`else
        checks++;
        if (draw !== 1'b0 || game_over !== 1'b0)
            $display("FAIL draw_flags: got draw=%b go=%b want 0 0", draw, game_over);
        else passes++;
        pulse_start(9'h007, 9'h000);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || winner !== 2'b01)
            $display("FAIL draw_restart: got cnt=%0d winner=%b want 1 01", cnt, winner);
        else passes++;
`endif
    endtask

    task automatic test_ignored_inputs();
        int cnt, at;
        clear_game();
        pulse_start(9'h00B, 9'h054);
        cnt = 0;
        at  = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                at = k;
            end
            if (k == 2) begin
                b_in  = 9'h1C0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (cnt !== 1 || at !== 8) $display("FAIL ignored_done: got cnt=%0d at=%0d want 1 at 8", cnt, at);
        else passes++;
        checks++;
        if (winner !== 2'b10 || win_line !== 8'h80)
            $display("FAIL ignored_result: got winner=%b line=%h want 10 80", winner, win_line);
        else passes++;
    endtask

    task automatic test_clear_mid();
        int cnt, at, busy_seen;
        clear_game();
        pulse_start(9'h007, 9'h018);
        repeat (3) @(negedge clk);
        clr_game = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        clr_game = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, winner, win_line, draw, game_over} !== 14'h0)
            $display("FAIL clear_mid_outputs: got %b want 0", {busy, done, winner, win_line, draw, game_over});
        else passes++;
        cnt       = 0;
        busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) cnt++;
            if (busy) busy_seen++;
        end
        checks++;
        if (cnt !== 0 || busy_seen !== 0)
            $display("FAIL clear_mid_quiet: got dones=%0d busy=%0d want 0 0", cnt, busy_seen);
        else passes++;
        pulse_start(9'h000, 9'h1C0);
        watch_done(cnt, at);
        checks++;
        if (cnt !== 1 || at !== 8 || winner !== 2'b10 || win_line !== 8'h04)
            $display("FAIL clear_restart: got cnt=%0d at=%0d winner=%b line=%h want 1 8 10 04",
                     cnt, at, winner, win_line);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_blue_row();
        test_start_in_over();
        test_red_diag();
        test_double_line();
        test_draw();
        test_ignored_inputs();
        test_clear_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/board_judge.md
# board_judge

Reads the two player occupancy vectors produced by the board register memory and decides the game result: blue win, red win, draw, or game still open. On a `start` pulse, issued by the game controller after each move is written, it snapshots both 9-bit boards and scans the 8 winning lines one per clock. It then reports the result with a one-cycle `done` pulse. It sits between the board memory outputs and the game controller / display logic.

## Interface
- Parameters: none. The board is fixed at 3x3, with 9 cells and 8 lines.
- `clk`  in  1  system clock; all state updates on the rising edge
- `clr_game`  in  1  reset, synchronous, active-high; also used as the new-game clear
- `start`  in  1  request evaluation; sampled only in IDLE
- `b_in`  in  9  blue occupancy; bit index = row*3+col, cell 0..8
- `r_in`  in  9  red occupancy; same indexing
- `busy`  out  1  high while in SCAN
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle onward
- `winner`  out  2  00 none, 01 blue, 10 red, 11 both (illegal board)
- `win_line`  out  8  one bit per completed line (either colour); bit k = line Lk
- `draw`  out  1  board full with no completed line
- `game_over`  out  1  sticky; set when `winner` != 00 or `draw` = 1

## Operation
- Line order (k: cells):
  - L0 {0,1,2}, L1 {3,4,5}, L2 {6,7,8}
  - L3 {0,3,6}, L4 {1,4,7}, L5 {2,5,8}
  - L6 {0,4,8}, L7 {2,4,6}
- States: IDLE, SCAN, DONE, OVER.
- IDLE, `start`=1:
  - capture `b_in` and `r_in` into snapshot registers
  - clear accumulators
  - load line index `idx`=0
  - go to SCAN
- SCAN: each cycle test line `idx` against the snapshot.
  - Blue complete: set blue-hit and `win_line[idx]`.
  - Red complete: set red-hit and `win_line[idx]`.
  - `idx` increments and does not wrap. On `idx`=7, go to DONE after the test.
  - The scan always covers all 8 lines; there is no early exit.
- Entering DONE, register the results:
  - `winner` = {red-hit, blue-hit}
  - `win_line` = accumulated hits
  - `draw` = (snapshot b|r == 9'h1FF) and no hit
  - `done`=1 for the DONE cycle
- DONE → OVER if `winner` != 00 or `draw`; otherwise → IDLE.
- OVER: `game_over`=1. Holds until `clr_game`; `start` is ignored.
- `start` during SCAN, DONE or OVER is ignored; no queuing.
- Board input changes after the capture edge do not affect the current result.
- Overlapping bits in b&r are not checked; the lines are evaluated per colour as given.
- Result outputs hold their last values in IDLE until the next DONE or `clr_game`.

## Timing
- Reset values (after any edge with `clr_game`=1), effective at the next edge:
  - state IDLE
  - `busy`=0, `done`=0, `winner`=00, `win_line`=8'h00, `draw`=0, `game_over`=0
  - snapshot and `idx` cleared
- `clr_game` has priority over everything, including `start` in the same cycle.
- `clr_game` mid-SCAN aborts the scan; no `done` is produced.
- Latency: `start` sampled at edge t → SCAN from t to t+8, with lines L0..L7 evaluated at edges t+1..t+8.
  - `done`=1 and results valid from t+8 to t+9.
  - `busy` is high from t to t+8.
- Next accepted `start`: from edge t+9 onward (state back in IDLE), unless the game is over.
- `game_over` rises together with `done` in the DONE cycle and stays high in OVER.

## Configuration
- `BOARD_JUDGE_DRAW_EN` defined:
  - draw detection is included, as described above
  - a full board with no line yields `draw`=1 and goes to OVER
- Undefined:
  - `draw` is tied to 0 and the full-board compare is not built
  - a full board with no line reports `winner`=00 and returns to IDLE (`game_over` stays 0)

## Test plan
- Blue row win: reset; `b_in`=9'h007, `r_in`=9'h018, `start` at edge t. Required:
  - `done` only in cycle t+8..t+9
  - `winner`=01, `win_line`=8'h01, `game_over`=1
- Red anti-diagonal win: `b_in`=9'h00B, `r_in`=9'h054. Required: `winner`=10, `win_line`=8'h80, `draw`=0.
- Double line: `b_in`=9'h04F, `r_in`=9'h1B0. Required: `winner`=01, `win_line`=8'h09.
- Draw: `b_in`=9'h18D, `r_in`=9'h072.
  - With macro: `winner`=00, `draw`=1, `game_over`=1.
  - Without macro: `draw`=0, `game_over`=0, state back in IDLE (a new `start` is accepted).
- Ignored inputs:
  - Change `b_in` to 9'h1C0 and pulse `start` during SCAN; the result still matches the captured board, and exactly one `done` is produced.
  - `start` in OVER produces no `done`.
- Reset mid-operation: `clr_game` at edge t+4 of a scan. Required:
  - from t+5 all outputs are 0 and no `done` is produced
  - a `start` coincident with `clr_game` is ignored
  - a `start` after the clear is accepted
